sram_read_streamer: RTL

Downstream consumer of the activation/weight buffer SRAM in the router datapath. On a start command it issues a burst of sequential read addresses to the single-cycle-latency SRAM and captures the returned words in a small elastic FIFO. It presents the words to the next router/PE stage on a valid/ready stream. Read issue is credit-limited, so no SRAM word is ever dropped under backpressure, even though the SRAM read port cannot stall.

---
 rtl/sram_read_streamer.sv | 125 ++++++++++++
 1 files changed

// File: rtl/sram_read_streamer.sv
// Streams a burst of sequential SRAM words onto a valid/ready interface.
// Reads are issued only while FIFO occupancy plus the in-flight read leaves room, so no word is dropped.
module sram_read_streamer #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 64,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  i_clk,
  input  logic                  i_nrst,
  input  logic                  i_start,
  input  logic [ADDR_WIDTH-1:0] i_base_addr,
  input  logic [ADDR_WIDTH:0]   i_count,
  output logic                  o_read_en,
  output logic [ADDR_WIDTH-1:0] o_read_addr,
  input  logic [DATA_WIDTH-1:0] i_sram_data,
  input  logic                  i_sram_valid,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic                  o_valid,
  input  logic                  i_ready,
  output logic                  o_busy,
  output logic                  o_done
);
  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [ADDR_WIDTH:0]   issue_left_q, issue_left_d;
  logic [ADDR_WIDTH:0]   pop_left_q, pop_left_d;
  logic                  inflight_q, inflight_d;
  logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];

  logic                  read_en;
  logic                  push;
  logic                  pop;
  logic [CW:0]           occupancy;

  always_comb begin
    occupancy    = (CW+1)'(count_q) + (CW+1)'(inflight_q);
    read_en      = (state_q == S_RUN) && (issue_left_q != '0) &&
                   (occupancy < (CW+1)'(FIFO_DEPTH));
    // Responses are only trusted when we actually issued the matching read.
    push         = inflight_q && i_sram_valid;
    pop          = (count_q != '0) && i_ready;

    state_d      = state_q;
    addr_d       = addr_q;
    issue_left_d = issue_left_q;
    pop_left_d   = pop_left_q;
    inflight_d   = read_en;
    rd_ptr_d     = rd_ptr_q;
    wr_ptr_d     = wr_ptr_q;
    count_d      = count_q;

    if (read_en) begin
      addr_d       = addr_q + ADDR_WIDTH'(1);
      issue_left_d = issue_left_q - (ADDR_WIDTH+1)'(1);
    end
    if (pop && (pop_left_q != '0)) begin
      pop_left_d = pop_left_q - (ADDR_WIDTH+1)'(1);
    end

    if (push) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
    if (push && !pop) begin
      count_d = count_q + CW'(1);
    end else if (!push && pop) begin
      count_d = count_q - CW'(1);
    end

    case (state_q)
      S_IDLE: begin
        if (i_start) begin
          addr_d       = i_base_addr;
          issue_left_d = i_count;
          pop_left_d   = i_count;
          state_d      = (i_count == '0) ? S_DONE : S_RUN;
        end
      end
      S_RUN:   if (issue_left_d == '0) state_d = S_DRAIN;
      S_DRAIN: if (pop_left_d == '0) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_nrst) begin
      state_q      <= S_IDLE;
      addr_q       <= '0;
      issue_left_q <= '0;
      pop_left_q   <= '0;
      inflight_q   <= 1'b0;
      rd_ptr_q     <= '0;
      wr_ptr_q     <= '0;
      count_q      <= '0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      issue_left_q <= issue_left_d;
      pop_left_q   <= pop_left_d;
      inflight_q   <= inflight_d;
      rd_ptr_q     <= rd_ptr_d;
      wr_ptr_q     <= wr_ptr_d;
      count_q      <= count_d;
    end
  end

  // Storage needs no reset; occupancy alone decides what is visible.
  always_ff @(posedge i_clk) begin
    if (push) mem_q[wr_ptr_q] <= i_sram_data;
  end

  assign o_read_en   = read_en;
  assign o_read_addr = addr_q;
  assign o_data      = mem_q[rd_ptr_q];
  assign o_valid     = (count_q != '0);
  assign o_busy      = (state_q != S_IDLE);
  assign o_done      = (state_q == S_DONE);
endmodule
